// File: rtl/lm70_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lm70_pkg
// Description : Shared states, frame constants and decode helper for the
//               LM70 SPI sampler.
// Revision    : 1.0 - initial release
// ============================================================================
package lm70_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } lm70_state_t;

    localparam int         LM70_FRAME_BITS = 16;
    localparam logic [4:0] LM70_ID_BITS    = 5'b11111;
    localparam int         LM70_RAW_W      = 11;

    // Dropping the two fractional bits of a signed value is a floor divide by 4.
    function automatic logic signed [8:0] lm70_raw_to_deg(input logic [LM70_RAW_W-1:0] raw);
        return $signed(raw[LM70_RAW_W-1:2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lm70_avg4.sv
`default_nettype none
// ============================================================================
// Module      : lm70_avg4
// Description : Running mean of the last four integer readings; produces
//               output only once four readings are in the history.
// Revision    : 1.0 - initial release
// ============================================================================
module lm70_avg4 (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic signed [8:0] in_deg_i,
    output logic              out_valid_o,
    output logic signed [8:0] out_deg_o
);

    logic signed [8:0]  h0_q, h1_q, h2_q;
    logic [1:0]         fill_q;
    logic               out_valid_q;
    logic signed [8:0]  out_deg_q;
    logic signed [10:0] sum_d;

    assign sum_d = 11'(in_deg_i) + 11'(h0_q) + 11'(h1_q) + 11'(h2_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            h0_q        <= '0;
            h1_q        <= '0;
            h2_q        <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_deg_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (in_valid_i) begin
                h0_q        <= in_deg_i;
                h1_q        <= h0_q;
                h2_q        <= h1_q;
                if (fill_q != 2'd3) begin
                    fill_q <= fill_q + 2'd1;
                end
                out_valid_q <= (fill_q == 2'd3);
                out_deg_q   <= sum_d[10:2];
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_deg_o   = out_deg_q;

endmodule
`default_nettype wire

// File: rtl/lm70_spi_sampler.sv
`default_nettype none
// ============================================================================
// Module      : lm70_spi_sampler
// Description : Continuous LM70 read frames over SPI, decoded to integer C
//               and presented on a valid/ready port. Macro LM70_AVG_EN
//               selects 4-sample running-mean output.
// Revision    : 1.0 - initial release
// ============================================================================
module lm70_spi_sampler
    import lm70_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        miso,
    output logic        cs_n,
    output logic        sck,
    output logic        temp_valid,
    input  logic        temp_ready,
    output logic [7:0]  temp_c,
    output logic        temp_neg,
    output logic [10:0] temp_raw,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    lm70_state_t                state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [4:0]                 bit_cnt_q;
    logic [LM70_FRAME_BITS-1:0] shift_q;
    logic                       cs_n_q;
    logic                       sck_q;

    logic                       hold_exit_d;
    logic                       id_ok_d;
    logic                       good_frame_d;
    logic [LM70_RAW_W-1:0]      frame_raw_d;
    logic signed [8:0]          frame_deg_d;

    assign hold_exit_d  = (state_q == HOLD) && (cnt_q == DIV_LAST);
    assign id_ok_d      = (shift_q[4:0] == LM70_ID_BITS);
    assign good_frame_d = hold_exit_d && id_ok_d;
    assign frame_raw_d  = shift_q[LM70_FRAME_BITS-1:5];
    assign frame_deg_d  = lm70_raw_to_deg(frame_raw_d);

    // The first bit is captured on the SETUP exit edge, which also raises sck.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q <= SETUP;
                        cs_n_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                SETUP: begin
                    if (cnt_q == DIV_LAST) begin
                        state_q   <= SHIFT;
                        cnt_q     <= '0;
                        sck_q     <= 1'b1;
                        shift_q   <= {shift_q[LM70_FRAME_BITS-2:0], miso};
                        bit_cnt_q <= 5'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (cnt_q != DIV_LAST) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q <= '0;
                        if (sck_q) begin
                            sck_q <= 1'b0;
                        end else if (bit_cnt_q == 5'(LM70_FRAME_BITS)) begin
                            state_q <= HOLD;
                        end else begin
                            sck_q     <= 1'b1;
                            shift_q   <= {shift_q[LM70_FRAME_BITS-2:0], miso};
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == DIV_LAST) begin
                        state_q <= GAP;
                        cs_n_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (run) begin
                            state_q <= SETUP;
                            cs_n_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cs_n_q  <= 1'b1;
                    sck_q   <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    logic                  load_d;
    logic signed [8:0]     load_deg_d;
    logic [LM70_RAW_W-1:0] load_raw_d;

`ifdef LM70_AVG_EN
    logic                  avg_valid;
    logic signed [8:0]     avg_deg;
    logic [LM70_RAW_W-1:0] raw_pend_q;
    logic                  avg_pend_q;

    lm70_avg4 u_avg4 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (good_frame_d),
        .in_deg_i    (frame_deg_d),
        .out_valid_o (avg_valid),
        .out_deg_o   (avg_deg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_pend_q <= '0;
            avg_pend_q <= 1'b0;
        end else begin
            avg_pend_q <= good_frame_d;
            if (good_frame_d) begin
                raw_pend_q <= frame_raw_d;
            end
        end
    end

    assign load_d     = avg_valid;
    assign load_deg_d = avg_deg;
    assign load_raw_d = raw_pend_q;
    assign busy       = !cs_n_q || avg_pend_q;
`else
    assign load_d     = good_frame_d;
    assign load_deg_d = frame_deg_d;
    assign load_raw_d = frame_raw_d;
    assign busy       = !cs_n_q;
`endif

    logic        valid_q;
    logic        overrun_q;
    logic        frame_err_q;
    logic [7:0]  temp_c_q;
    logic        temp_neg_q;
    logic [10:0] temp_raw_q;

    // A load coinciding with a handshake replaces the accepted sample seamlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            temp_c_q    <= '0;
            temp_neg_q  <= 1'b0;
            temp_raw_q  <= '0;
        end else begin
            frame_err_q <= hold_exit_d && !id_ok_d;
            if (load_d) begin
                temp_neg_q <= load_deg_d[8];
                temp_c_q   <= load_deg_d[8] ? 8'd0 : load_deg_d[7:0];
                temp_raw_q <= load_raw_d;
                valid_q    <= 1'b1;
                if (valid_q && !temp_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && temp_ready) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign cs_n       = cs_n_q;
    assign sck        = sck_q;
    assign temp_valid = valid_q;
    assign temp_c     = temp_c_q;
    assign temp_neg   = temp_neg_q;
    assign temp_raw   = temp_raw_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_lm70_spi_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lm70_spi_sampler
// Description : Directed self-checking bench with a behavioural LM70 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lm70_spi_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        miso;
    logic        cs_n, sck, temp_valid, temp_neg, busy, frame_err, overrun;
    logic        temp_ready = 1'b1;
    logic [7:0]  temp_c;
    logic [10:0] temp_raw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lm70_spi_sampler dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .miso       (miso),
        .cs_n       (cs_n),
        .sck        (sck),
        .temp_valid (temp_valid),
        .temp_ready (temp_ready),
        .temp_c     (temp_c),
        .temp_neg   (temp_neg),
        .temp_raw   (temp_raw),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    // LM70 model: frame latched at cs_n fall, next bit presented after each sck fall
    logic [15:0] next_frame = 16'h0000;
    logic [15:0] cur_frame  = 16'h0000;
    int          bit_idx    = 16;

    always @(negedge cs_n) begin
        cur_frame = next_frame;
        bit_idx   = 0;
    end
    always @(negedge sck) bit_idx = bit_idx + 1;
    assign miso = (bit_idx < 16) ? cur_frame[4'(15 - bit_idx)] : 1'b0;

    int sck_rises  = 0;
    int cs_low_cnt = 0;
    int hs_cnt     = 0;
    int err_cnt    = 0;

    always @(posedge sck) sck_rises = sck_rises + 1;
    always @(negedge clk) begin
        if (!cs_n) cs_low_cnt = cs_low_cnt + 1;
        if (temp_valid && temp_ready) hs_cnt = hs_cnt + 1;
        if (frame_err) err_cnt = err_cnt + 1;
    end

    // Returns on the first negedge after cs_n rises again
    task automatic run_frame(input logic [15:0] frame, input logic drop_run);
        int n;
        next_frame = frame;
        n = 0;
        while (cs_n !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (cs_n !== 1'b0) begin
            errors++;
            $display("FAIL frame_start: cs_n=%b required 0 within 300 cycles", cs_n);
        end
        if (drop_run) run = 1'b0;
        n = 0;
        while (cs_n !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (cs_n !== 1'b1) begin
            errors++;
            $display("FAIL frame_end: cs_n=%b required 1 within 300 cycles", cs_n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_n, sck, temp_valid, temp_c, temp_neg, temp_raw, busy, frame_err, overrun}
            !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: cs_n=%b sck=%b valid=%b c=%0d neg=%b raw=%h busy=%b err=%b ovr=%b required 1 0 0 0 0 000 0 0 0",
                     cs_n, sck, temp_valid, temp_c, temp_neg, temp_raw, busy, frame_err, overrun);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int hs0;
        temp_ready = 1'b1;
        sck_rises  = 0;
        cs_low_cnt = 0;
        hs0        = hs_cnt;
        run        = 1'b1;
        run_frame(16'h0C9F, 1'b0);
        checks++;
        if (sck_rises != 16) begin
            errors++; $display("FAIL sck_count: got %0d required 16", sck_rises);
        end
        checks++;
        if (cs_low_cnt != 68) begin
            errors++; $display("FAIL cs_low_len: got %0d required 68", cs_low_cnt);
        end
        checks++;
        if ({temp_valid, temp_c, temp_neg, temp_raw} !== {1'b1, 8'd25, 1'b0, 11'h064}) begin
            errors++;
            $display("FAIL basic_25C: valid=%b c=%0d neg=%b raw=%h required 1 25 0 064",
                     temp_valid, temp_c, temp_neg, temp_raw);
        end
        @(negedge clk);
        checks++;
        if (temp_valid !== 1'b0) begin
            errors++; $display("FAIL basic_valid_1cyc: valid=%b required 0", temp_valid);
        end
        checks++;
        if (hs_cnt - hs0 != 1) begin
            errors++; $display("FAIL basic_handshakes: got %0d required 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_decode;
        run_frame(16'hF39F, 1'b0);
        checks++;
        if ({temp_valid, temp_c, temp_neg, temp_raw} !== {1'b1, 8'd0, 1'b1, 11'h79C}) begin
            errors++;
            $display("FAIL decode_neg25: valid=%b c=%0d neg=%b raw=%h required 1 0 1 79c",
                     temp_valid, temp_c, temp_neg, temp_raw);
        end
        run_frame(16'h4B1F, 1'b0);
        checks++;
        if ({temp_valid, temp_c, temp_neg, temp_raw} !== {1'b1, 8'd150, 1'b0, 11'h258}) begin
            errors++;
            $display("FAIL decode_150: valid=%b c=%0d neg=%b raw=%h required 1 150 0 258",
                     temp_valid, temp_c, temp_neg, temp_raw);
        end
    endtask

    task automatic test_frame_err;
        int e0;
        @(negedge clk);
        e0 = err_cnt;
        run_frame(16'h0C80, 1'b0);
        checks++;
        if ({frame_err, temp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bad_id_pulse: err=%b valid=%b required 1 0", frame_err, temp_valid);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({frame_err, temp_valid} !== 2'b00 || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL bad_id_once: err=%b valid=%b pulses=%0d required 0 0 1",
                     frame_err, temp_valid, err_cnt - e0);
        end
        run_frame(16'h0C9F, 1'b0);
        checks++;
        if ({temp_valid, temp_c} !== {1'b1, 8'd25}) begin
            errors++;
            $display("FAIL after_bad_25C: valid=%b c=%0d required 1 25", temp_valid, temp_c);
        end
        @(negedge clk);
    endtask

    task automatic test_overrun;
        int hs0;
        temp_ready = 1'b0;
        hs0        = hs_cnt;
        run_frame(16'h0C9F, 1'b0);
        checks++;
        if ({temp_valid, temp_c, overrun} !== {1'b1, 8'd25, 1'b0}) begin
            errors++;
            $display("FAIL ovr_first: valid=%b c=%0d ovr=%b required 1 25 0", temp_valid, temp_c, overrun);
        end
        run_frame(16'h0D1F, 1'b1);
        checks++;
        if ({temp_valid, temp_c, overrun} !== {1'b1, 8'd26, 1'b1}) begin
            errors++;
            $display("FAIL ovr_second: valid=%b c=%0d ovr=%b required 1 26 1", temp_valid, temp_c, overrun);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({temp_valid, temp_c, overrun} !== {1'b1, 8'd26, 1'b1}) begin
            errors++;
            $display("FAIL ovr_held: valid=%b c=%0d ovr=%b required 1 26 1", temp_valid, temp_c, overrun);
        end
        temp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({temp_valid, overrun} !== 2'b00 || hs_cnt - hs0 != 1) begin
            errors++;
            $display("FAIL ovr_accept: valid=%b ovr=%b handshakes=%0d required 0 0 1",
                     temp_valid, overrun, hs_cnt - hs0);
        end
        repeat (12) @(negedge clk);
        checks++;
        if ({cs_n, busy} !== 2'b10) begin
            errors++; $display("FAIL run_stop_idle: cs_n=%b busy=%b required 1 0", cs_n, busy);
        end
    endtask

    task automatic test_reset_midframe;
        int n;
        next_frame = 16'h0C9F;
        sck_rises  = 0;
        run        = 1'b1;
        n = 0;
        while (sck_rises < 7 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (sck_rises < 7) begin
            errors++; $display("FAIL midframe_reach: sck rises=%0d required 7", sck_rises);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cs_n, sck, temp_valid, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL midframe_reset: cs_n=%b sck=%b valid=%b busy=%b required 1 0 0 0",
                     cs_n, sck, temp_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        run_frame(16'h4B1F, 1'b1);
        checks++;
        if ({temp_valid, temp_c, temp_neg} !== {1'b1, 8'd150, 1'b0}) begin
            errors++;
            $display("FAIL after_reset_150: valid=%b c=%0d neg=%b required 1 150 0",
                     temp_valid, temp_c, temp_neg);
        end
    endtask

    task automatic test_avg;
        int hs0;
        temp_ready = 1'b1;
        hs0        = hs_cnt;
        run        = 1'b1;
        run_frame(16'h0A1F, 1'b0);
        run_frame(16'h0A1F, 1'b0);
        run_frame(16'h0C1F, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (hs_cnt - hs0 != 0 || temp_valid !== 1'b0) begin
            errors++;
            $display("FAIL avg_warmup: outputs=%0d valid=%b required 0 0", hs_cnt - hs0, temp_valid);
        end
        run_frame(16'h0C1F, 1'b0);
        checks++;
        if (temp_valid !== 1'b0) begin
            errors++; $display("FAIL avg_latency: valid=%b required 0 at cs_n rise", temp_valid);
        end
        @(negedge clk);
        checks++;
        if ({temp_valid, temp_c, temp_raw} !== {1'b1, 8'd22, 11'h060}) begin
            errors++;
            $display("FAIL avg_22: valid=%b c=%0d raw=%h required 1 22 060", temp_valid, temp_c, temp_raw);
        end
        run_frame(16'h0E1F, 1'b1);
        @(negedge clk);
        checks++;
        if ({temp_valid, temp_c, temp_raw} !== {1'b1, 8'd24, 11'h070}) begin
            errors++;
            $display("FAIL avg_24: valid=%b c=%0d raw=%h required 1 24 070", temp_valid, temp_c, temp_raw);
        end
    endtask

    initial begin
        test_reset;
`ifdef LM70_AVG_EN
        test_avg;
`else
        test_basic;
        test_decode;
        test_frame_err;
        test_overrun;
        test_reset_midframe;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
